cdb_arbiter: RTL and testbench

- Result-return stage between the functional units and the common data bus.
- Each functional unit hands over completed results (value, destination register, issue ID), which are buffered in a per-unit FIFO.
- Round-robin selects one result per cycle to broadcast on the CDB; the reservation stations and register status logic snoop that broadcast to wake waiting operands.
- Speculative results are squashed or committed with the branch-resolution signals.

---
 rtl/cdb_arbiter_if.sv | 32 +++
 rtl/cdb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units / branch unit and the CDB arbiter.
// The arbiter takes the slave view; the producer/consumer side takes master.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4
);
    logic [NUM_FU-1:0]    fu_valid;
    logic [NUM_FU-1:0]    fu_ready;
    logic [64*NUM_FU-1:0] fu_result;
    logic [5*NUM_FU-1:0]  fu_dest;
    logic [32*NUM_FU-1:0] fu_iss_id;
    logic [NUM_FU-1:0]    fu_spec;
    logic                 prediction_failed;
    logic                 prediction_success;
    logic [63:0]          CDB;
    logic [4:0]           CDB_REG_ID;
    logic [3:0]           CDB_FU_ID;
    logic [31:0]          CDB_ISS_ID;
    logic                 cdb_valid;
    logic                 busy;

    modport master (
        output fu_valid, fu_result, fu_dest, fu_iss_id, fu_spec,
        output prediction_failed, prediction_success,
        input  fu_ready, CDB, CDB_REG_ID, CDB_FU_ID, CDB_ISS_ID, cdb_valid, busy
    );

    modport slave (
        input  fu_valid, fu_result, fu_dest, fu_iss_id, fu_spec,
        input  prediction_failed, prediction_success,
        output fu_ready, CDB, CDB_REG_ID, CDB_FU_ID, CDB_ISS_ID, cdb_valid, busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Result-return stage: per-FU result FIFOs with speculative squash/commit and a
// round-robin picker that registers at most one broadcast per cycle onto the CDB.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int FU_ID_BASE = 1
) (
    input  logic         clk,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] ready, push, pop, nonempty, scrub, cand, grant_vec;
    logic [NUM_FU-1:0] head_live, head_spec;
    logic [63:0]       head_result [NUM_FU];
    logic [4:0]        head_dest   [NUM_FU];
    logic [31:0]       head_iss    [NUM_FU];

    logic              squash, commit;
    logic              grant_any;
    logic [RR_W-1:0]   grant_idx;
    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    int                scan_idx;

    logic [63:0]       cdb_q, cdb_d;
    logic [4:0]        reg_id_q, reg_id_d;
    logic [3:0]        fu_id_q, fu_id_d;
    logic [31:0]       iss_q, iss_d;
    logic              cdb_valid;

    // A failed prediction wins over a simultaneous success.
    assign squash = bus.prediction_failed;
    assign commit = bus.prediction_success && !bus.prediction_failed;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        logic [63:0]           result_q [FIFO_DEPTH];
        logic [4:0]            dest_q   [FIFO_DEPTH];
        logic [31:0]           iss_id_q [FIFO_DEPTH];
        logic [FIFO_DEPTH-1:0] spec_q, spec_d, live_q, live_d;
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      count_q, count_d;
        logic [4:0]            in_dest;
        logic                  in_spec;

        assign in_dest          = bus.fu_dest[5*gi +: 5];
        assign in_spec          = bus.fu_spec[gi];
        assign ready[gi]        = (count_q < CNT_W'(FIFO_DEPTH));
        assign push[gi]         = bus.fu_valid[gi] && ready[gi];
        assign nonempty[gi]     = (count_q != '0);
        assign head_live[gi]    = live_q[rd_ptr_q];
        assign head_spec[gi]    = spec_q[rd_ptr_q];
        assign head_result[gi]  = result_q[rd_ptr_q];
        assign head_dest[gi]    = dest_q[rd_ptr_q];
        assign head_iss[gi]     = iss_id_q[rd_ptr_q];

        assign wr_ptr_d = push[gi] ? wr_ptr_q + 1'b1 : wr_ptr_q;
        assign rd_ptr_d = pop[gi]  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        always_comb begin
            case ({push[gi], pop[gi]})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Branch resolution touches every entry; a same-cycle write sees it too.
        always_comb begin
            spec_d = spec_q;
            live_d = live_q;
            if (squash) begin
                live_d = live_q & ~spec_q;
            end else if (commit) begin
                spec_d = '0;
            end
            if (push[gi]) begin
                spec_d[wr_ptr_q] = in_spec && !commit;
                live_d[wr_ptr_q] = (in_dest != 5'd0) && !(in_spec && squash);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                spec_q   <= '0;
                live_q   <= '0;
            end else begin
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                spec_q   <= spec_d;
                live_q   <= live_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push[gi]) begin
                result_q[wr_ptr_q] <= bus.fu_result[64*gi +: 64];
                dest_q[wr_ptr_q]   <= in_dest;
                iss_id_q[wr_ptr_q] <= bus.fu_iss_id[32*gi +: 32];
            end
        end
    end

    // Dead heads leave without a CDB slot; spec heads sit out a squash cycle.
    assign scrub = nonempty & ~head_live;
    assign cand  = nonempty & head_live & ~(head_spec & {NUM_FU{squash}});
    assign pop   = scrub | grant_vec;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        scan_idx  = 0;
        for (int off = 0; off < NUM_FU; off++) begin
            scan_idx = int'(rr_ptr_q) + off;
            if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
            if (!grant_any && cand[RR_W'(scan_idx)]) begin
                grant_any = 1'b1;
                grant_idx = RR_W'(scan_idx);
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
    end

    assign rr_ptr_d = !grant_any ? rr_ptr_q :
                      (grant_idx == RR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        cdb_d    = '0;
        reg_id_d = '0;
        fu_id_d  = '0;
        iss_d    = '0;
        if (grant_any) begin
            cdb_d    = head_result[grant_idx];
            reg_id_d = head_dest[grant_idx];
            fu_id_d  = 4'(FU_ID_BASE + int'(grant_idx));
            iss_d    = head_iss[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
            reg_id_q <= '0;
            fu_id_q  <= '0;
            iss_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
            reg_id_q <= reg_id_d;
            fu_id_q  <= fu_id_d;
            iss_q    <= iss_d;
        end
    end

    assign cdb_valid      = (reg_id_q != 5'd0);
    assign bus.fu_ready   = ready;
    assign bus.CDB        = cdb_q;
    assign bus.CDB_REG_ID = reg_id_q;
    assign bus.CDB_FU_ID  = fu_id_q;
    assign bus.CDB_ISS_ID = iss_q;
    assign bus.cdb_valid  = cdb_valid;
    assign bus.busy       = (|nonempty) || cdb_valid;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table-driven directed rows, hand sequences for backpressure
// and async reset, then random traffic against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int NUM_FU     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int FU_ID_BASE = 1;
    localparam int NROWS      = 25;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cdb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

    cdb_arbiter #(
        .NUM_FU    (NUM_FU),
        .FIFO_DEPTH(FIFO_DEPTH),
        .FU_ID_BASE(FU_ID_BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dest;
        logic [31:0] iss;
        logic        spec;
        logic        live;
    } ent_t;

    typedef struct {
        logic [3:0] v;
        logic [3:0] s;
        logic [4:0] db;
        logic       pf;
        logic       ps;
        logic       ev;
        logic [3:0] efu;
        logic [4:0] ereg;
        logic       eb;
    } row_t;

    ent_t        mq   [NUM_FU][$];
    ent_t        pend [NUM_FU][$];
    int          m_rr;
    logic [105:0] m_out;
    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_cnt [NUM_FU];
    logic [31:0] obs0 [$];
    row_t        tbl [NROWS];
    int          iss_ctr = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            mq[i].delete();
            pend[i].delete();
        end
        m_rr  = 0;
        m_out = '0;
    endtask

    // Reference: queues per port; one step = arbitrate, pop, resolve branch, accept.
    task automatic model_step();
        logic pf, ps;
        int   g, p;
        ent_t e;
        logic acc [NUM_FU];
        pf = bus.prediction_failed;
        ps = bus.prediction_success && !pf;
        for (int i = 0; i < NUM_FU; i++)
            acc[i] = bus.fu_valid[i] && (mq[i].size() < FIFO_DEPTH);
        g = -1;
        for (int k = 0; k < NUM_FU; k++) begin
            p = (m_rr + k) % NUM_FU;
            if (g < 0 && mq[p].size() > 0)
                if (mq[p][0].live && !(mq[p][0].spec && pf)) g = p;
        end
        if (g >= 0) begin
            e = mq[g][0];
            m_out = {e.res, e.dest, 4'((FU_ID_BASE + g) % 16), e.iss, 1'b1};
        end else begin
            m_out = '0;
        end
        for (int i = 0; i < NUM_FU; i++)
            if (mq[i].size() > 0)
                if (!mq[i][0].live || i == g) void'(mq[i].pop_front());
        for (int i = 0; i < NUM_FU; i++)
            for (int j = 0; j < mq[i].size(); j++) begin
                e = mq[i][j];
                if (pf) begin
                    if (e.spec) e.live = 1'b0;
                end else if (ps) begin
                    e.spec = 1'b0;
                end
                mq[i][j] = e;
            end
        for (int i = 0; i < NUM_FU; i++)
            if (acc[i]) begin
                e.res  = bus.fu_result[64*i +: 64];
                e.dest = bus.fu_dest[5*i +: 5];
                e.iss  = bus.fu_iss_id[32*i +: 32];
                e.spec = bus.fu_spec[i] && !ps;
                e.live = (e.dest != 5'd0) && !(bus.fu_spec[i] && pf);
                mq[i].push_back(e);
            end
        if (g >= 0) m_rr = (g + 1) % NUM_FU;
    endtask

    function automatic int model_fill();
        int n;
        n = 0;
        for (int i = 0; i < NUM_FU; i++) n += mq[i].size() + pend[i].size();
        return n;
    endfunction

    task automatic drive_pending();
        for (int i = 0; i < NUM_FU; i++) begin
            if (pend[i].size() > 0) begin
                bus.fu_valid[i]            = 1'b1;
                bus.fu_result[64*i +: 64]  = pend[i][0].res;
                bus.fu_dest[5*i +: 5]      = pend[i][0].dest;
                bus.fu_iss_id[32*i +: 32]  = pend[i][0].iss;
                bus.fu_spec[i]             = pend[i][0].spec;
            end else begin
                bus.fu_valid[i]            = 1'b0;
                bus.fu_result[64*i +: 64]  = '0;
                bus.fu_dest[5*i +: 5]      = '0;
                bus.fu_iss_id[32*i +: 32]  = '0;
                bus.fu_spec[i]             = 1'b0;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.fu_valid           = '0;
        bus.fu_result          = '0;
        bus.fu_dest            = '0;
        bus.fu_iss_id          = '0;
        bus.fu_spec            = '0;
        bus.prediction_failed  = 1'b0;
        bus.prediction_success = 1'b0;
    endtask

    task automatic cycle();
        logic hs [NUM_FU];
        logic [NUM_FU-1:0] exp_ready;
        logic exp_busy;
        for (int i = 0; i < NUM_FU; i++) hs[i] = bus.fu_valid[i] && bus.fu_ready[i];
        model_step();
        @(posedge clk);
        #1;
        exp_busy = m_out[0];
        for (int i = 0; i < NUM_FU; i++) begin
            exp_ready[i] = (mq[i].size() < FIFO_DEPTH);
            if (mq[i].size() > 0) exp_busy = 1'b1;
        end
        chk("cdb", 128'({bus.CDB, bus.CDB_REG_ID, bus.CDB_FU_ID, bus.CDB_ISS_ID, bus.cdb_valid}),
            128'(m_out));
        chk("busy", 128'(bus.busy), 128'(exp_busy));
        chk("ready", 128'(bus.fu_ready), 128'(exp_ready));
        if (bus.cdb_valid) begin
            $display("cdb: fu=%0d reg=%0d iss=%h val=%h", bus.CDB_FU_ID, bus.CDB_REG_ID,
                     bus.CDB_ISS_ID, bus.CDB);
            if (bus.CDB_FU_ID == 4'(FU_ID_BASE)) obs0.push_back(bus.CDB_ISS_ID);
        end
        for (int i = 0; i < NUM_FU; i++)
            if (hs[i]) begin
                acc_cnt[i]++;
                if (pend[i].size() > 0) void'(pend[i].pop_front());
            end
    endtask

    function automatic row_t mk(input logic [3:0] v, input logic [3:0] s, input logic [4:0] db,
                                input logic pf, input logic ps, input logic ev,
                                input logic [3:0] efu, input logic [4:0] ereg, input logic eb);
        row_t r;
        r.v = v; r.s = s; r.db = db; r.pf = pf; r.ps = ps;
        r.ev = ev; r.efu = efu; r.ereg = ereg; r.eb = eb;
        return r;
    endfunction

    function automatic ent_t mk_ent(input logic [4:0] dest, input logic [31:0] iss, input logic spec);
        ent_t e;
        e.res  = {$urandom, $urandom};
        e.dest = dest;
        e.iss  = iss;
        e.spec = spec;
        e.live = 1'b1;
        return e;
    endfunction

    initial begin
        int drop_at;
        logic [4:0] rd;

        // dest of port i is db+i (5-bit wrap); expectations observed after the row's edge
        tbl[0]  = mk(4'b1111, 4'b0000,  8, 0, 0, 0, 0,  0, 1);
        tbl[1]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 1,  8, 1);
        tbl[2]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 2,  9, 1);
        tbl[3]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 3, 10, 1);
        tbl[4]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 4, 11, 1);
        tbl[5]  = mk(4'b1111, 4'b0000, 12, 0, 0, 0, 0,  0, 1);
        tbl[6]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 1, 12, 1);
        tbl[7]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 2, 13, 1);
        tbl[8]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 3, 14, 1);
        tbl[9]  = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 4, 15, 1);
        tbl[10] = mk(4'b0000, 4'b0000,  0, 0, 0, 0, 0,  0, 0);
        tbl[11] = mk(4'b0100, 4'b0000,  3, 0, 0, 0, 0,  0, 1);
        tbl[12] = mk(4'b0000, 4'b0000,  0, 0, 0, 1, 3,  5, 1);
        tbl[13] = mk(4'b0000, 4'b0000,  0, 0, 0, 0, 0,  0, 0);
        tbl[14] = mk(4'b0011, 4'b0001, 20, 0, 0, 0, 0,  0, 1);
        tbl[15] = mk(4'b0000, 4'b0000,  0, 1, 0, 1, 2, 21, 1);
        tbl[16] = mk(4'b0000, 4'b0000,  0, 0, 0, 0, 0,  0, 0);
        tbl[17] = mk(4'b1000, 4'b1000,  1, 0, 0, 0, 0,  0, 1);
        tbl[18] = mk(4'b0000, 4'b0000,  0, 1, 1, 0, 0,  0, 1);
        tbl[19] = mk(4'b0000, 4'b0000,  0, 0, 0, 0, 0,  0, 0);
        tbl[20] = mk(4'b1000, 4'b1000,  1, 0, 1, 0, 0,  0, 1);
        tbl[21] = mk(4'b0000, 4'b0000,  0, 1, 0, 1, 4,  4, 1);
        tbl[22] = mk(4'b0000, 4'b0000,  0, 0, 0, 0, 0,  0, 0);
        tbl[23] = mk(4'b0010, 4'b0000, 31, 0, 0, 0, 0,  0, 1);
        tbl[24] = mk(4'b0000, 4'b0000,  0, 0, 0, 0, 0,  0, 0);

        for (int i = 0; i < NUM_FU; i++) acc_cnt[i] = 0;
        clear_inputs();
        model_reset();
        #2;
        chk("reset_out", 128'({bus.CDB, bus.CDB_REG_ID, bus.CDB_FU_ID, bus.CDB_ISS_ID,
                               bus.cdb_valid, bus.busy}), 128'(0));
        #10 reset = 1'b0;
        #1;
        chk("reset_ready", 128'({bus.fu_ready, bus.busy}), 128'({4'hF, 1'b0}));

        for (int r = 0; r < NROWS; r++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                bus.fu_valid[i]           = tbl[r].v[i];
                bus.fu_spec[i]            = tbl[r].s[i];
                bus.fu_dest[5*i +: 5]     = 5'(int'(tbl[r].db) + i);
                bus.fu_result[64*i +: 64] = {16'hC0DE, 16'(r), 32'(i)};
                bus.fu_iss_id[32*i +: 32] = 32'(r * 16 + i);
            end
            bus.prediction_failed  = tbl[r].pf;
            bus.prediction_success = tbl[r].ps;
            cycle();
            chk($sformatf("tbl_row%0d", r),
                128'({bus.cdb_valid, bus.CDB_FU_ID, bus.CDB_REG_ID, bus.busy, bus.fu_ready}),
                128'({tbl[r].ev, tbl[r].efu, tbl[r].ereg, tbl[r].eb, 4'hF}));
        end
        clear_inputs();

        // Backpressure: a warm-up broadcast from port 0 moves the pointer to port 1.
        pend[0].push_back(mk_ent(5'd9, 32'hA0, 1'b0));
        for (int c = 0; c < 3; c++) begin
            drive_pending();
            cycle();
        end
        obs0.delete();
        acc_cnt[0] = 0;
        drop_at = -1;
        for (int k = 0; k < 3; k++) pend[0].push_back(mk_ent(5'(k + 1), 32'hB0 + 32'(k), 1'b0));
        for (int k = 0; k < 6; k++) pend[1].push_back(mk_ent(5'(k + 10), 32'hC0 + 32'(k), 1'b0));
        for (int c = 0; c < 40; c++) begin
            drive_pending();
            cycle();
            if (!bus.fu_ready[0] && drop_at < 0) drop_at = acc_cnt[0];
            if (model_fill() == 0 && !m_out[0]) break;
        end
        clear_inputs();
        chk("bp_ready_drop", 128'(drop_at), 128'(2));
        chk("bp_count", 128'(obs0.size()), 128'(3));
        for (int k = 0; k < 3; k++)
            if (k < obs0.size()) chk("bp_order", 128'(obs0[k]), 128'(32'hB0 + 32'(k)));

        // Async reset with three results buffered.
        for (int i = 0; i < 3; i++) pend[i].push_back(mk_ent(5'(i + 1), 32'hD0 + 32'(i), 1'b0));
        drive_pending();
        cycle();
        clear_inputs();
        #2 reset = 1'b1;
        #1;
        chk("rst_async", 128'({bus.CDB, bus.CDB_REG_ID, bus.CDB_FU_ID, bus.CDB_ISS_ID,
                               bus.cdb_valid, bus.busy}), 128'(0));
        #2 reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("rst_quiet", 128'(bus.cdb_valid), 128'(0));
        end

        // Random traffic; each FU holds its offer until accepted.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                if (pend[i].size() == 0 && $urandom_range(0, 9) < 4) begin
                    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pend[i].push_back(mk_ent(rd, 32'(iss_ctr), ($urandom_range(0, 2) == 0)));
                    iss_ctr++;
                end
            drive_pending();
            bus.prediction_failed  = ($urandom_range(0, 11) == 0);
            bus.prediction_success = ($urandom_range(0, 7) == 0);
            cycle();
        end
        bus.prediction_failed  = 1'b0;
        bus.prediction_success = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive_pending();
            cycle();
            if (model_fill() == 0 && !m_out[0]) break;
        end
        clear_inputs();
        chk("drain_model", 128'(model_fill()), 128'(0));
        chk("drain_busy", 128'(bus.busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
